// File: rtl/alu_pkg.sv
// alu_pkg: ALU select codes, RV32I opcodes and the issue FSM state type.
package alu_pkg;
  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_SLT = 4'b0111;
  localparam logic [3:0] ALU_NOR = 4'b1100;
  localparam logic [3:0] ALU_EQ  = 4'b1111;
  localparam logic [6:0] OP_R  = 7'b0110011;
  localparam logic [6:0] OP_I  = 7'b0010011;
  localparam logic [6:0] OP_BR = 7'b1100011;
  typedef enum logic [1:0] {S_IDLE, S_EXEC, S_DONE} state_t;
endpackage

// File: rtl/alu_issue_decode.sv
// alu_issue_decode: combinational RV32I ALU-op decode into {sel, use_imm, illegal}.
module alu_issue_decode
  import alu_pkg::*;
(
  input  logic [31:0] instr,
  output logic [3:0]  sel,
  output logic        use_imm,
  output logic        illegal
);
  logic [6:0] op, f7;
  logic [2:0] f3;
  logic [3:0] fsel;
  logic       fok, r_sub, r_ok, i_ok, beq, unused_bits;
  assign op = instr[6:0];
  assign f3 = instr[14:12];
  assign f7 = instr[31:25];
  assign unused_bits = ^{instr[24:15], instr[11:7]};
  // funct3 mapping shared by R-type and I-type
  always_comb begin
    fsel = ALU_ADD;
    fok = 1'b1;
    case (f3)
      3'b000:  fsel = ALU_ADD;
      3'b111:  fsel = ALU_AND;
      3'b110:  fsel = ALU_OR;
      3'b010:  fsel = ALU_SLT;
      default: fok = 1'b0;
    endcase
  end
  assign r_sub = op == OP_R && f3 == 3'b000 && f7 == 7'b0100000;
  assign r_ok = op == OP_R && f7 == 7'b0000000 && fok;
  assign i_ok = op == OP_I && fok;
  assign beq = op == OP_BR && f3 == 3'b000;
  assign illegal = !(r_sub || r_ok || i_ok || beq);
  assign use_imm = i_ok;
  assign sel = r_sub ? ALU_SUB : beq ? ALU_EQ : (r_ok || i_ok) ? fsel : ALU_ADD;
endmodule

// File: rtl/alu_issue_ctrl.sv
// alu_issue_ctrl: valid/ready issue controller around an external combinational ALU.
// Optional ALU_OVF_TRAP_EN: signed overflow on R-type ADD/SUB raises out_trap and zeroes the result.
module alu_issue_ctrl
  import alu_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [31:0]       in_instr,
  input  logic [DATA_W-1:0] in_rs1,
  input  logic [DATA_W-1:0] in_rs2,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output logic [3:0]        alu_sel,
  input  logic [DATA_W-1:0] alu_result,
  input  logic              alu_zero,
  input  logic              alu_carry,
  input  logic              alu_overflow,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_result,
  output logic              out_zero,
  output logic              out_carry,
  output logic              out_overflow,
  output logic              out_illegal,
  output logic              out_trap
);
  state_t            state;
  logic              illegal_q, dec_imm, dec_ill, accept, trap;
  logic [3:0]        dec_sel;
  logic [DATA_W-1:0] imm;
  alu_issue_decode u_dec (
    .instr(in_instr),
    .sel(dec_sel),
    .use_imm(dec_imm),
    .illegal(dec_ill)
  );
  assign imm = {{(DATA_W-12){in_instr[31]}}, in_instr[31:20]};
  assign in_ready = !reset && (state == S_IDLE || (state == S_DONE && out_ready));
  assign accept = in_valid && in_ready;
`ifdef ALU_OVF_TRAP_EN
  logic ovf_chk;
  always_ff @(posedge clk) begin
    if (reset) ovf_chk <= 1'b0;
    else if (accept) ovf_chk <= !dec_ill && !dec_imm && (dec_sel == ALU_ADD || dec_sel == ALU_SUB);
  end
  assign trap = ovf_chk && alu_overflow;
`else
  assign trap = 1'b0;
`endif
  // accept has priority: from DONE it both retires the result and starts the next op
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_IDLE;
      out_valid <= 1'b0;
      alu_a <= '0;
      alu_b <= '0;
      alu_sel <= 4'b0000;
      illegal_q <= 1'b0;
      out_result <= '0;
      out_zero <= 1'b0;
      out_carry <= 1'b0;
      out_overflow <= 1'b0;
      out_illegal <= 1'b0;
      out_trap <= 1'b0;
    end else if (accept) begin
      state <= S_EXEC;
      out_valid <= 1'b0;
      alu_a <= dec_ill ? '0 : in_rs1;
      alu_b <= dec_ill ? '0 : dec_imm ? imm : in_rs2;
      alu_sel <= dec_sel;
      illegal_q <= dec_ill;
    end else if (state == S_EXEC) begin
      state <= S_DONE;
      out_valid <= 1'b1;
      out_result <= (illegal_q || trap) ? '0 : alu_result;
      out_zero <= !illegal_q && alu_zero;
      out_carry <= !illegal_q && alu_carry;
      out_overflow <= !illegal_q && alu_overflow;
      out_illegal <= illegal_q;
      out_trap <= trap;
    end else if (state == S_DONE && out_ready) begin
      state <= S_IDLE;
      out_valid <= 1'b0;
    end
  end
endmodule

// File: tb/tb_alu_issue_ctrl.sv
// tb_alu_issue_ctrl: table-driven check of alu_issue_ctrl with a behavioural ALU attached.
module tb_alu_issue_ctrl;
  import alu_pkg::*;
`ifdef ALU_OVF_TRAP_EN
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif
  logic        clk = 1'b0, reset, in_valid, in_ready, out_valid, out_ready;
  logic [31:0] in_instr, in_rs1, in_rs2, alu_a, alu_b, alu_result, out_result;
  logic [3:0]  alu_sel;
  logic        alu_zero, alu_carry, alu_overflow;
  logic        out_zero, out_carry, out_overflow, out_illegal, out_trap;
  logic [32:0] add_s, sub_s;
  int          n_tests = 0, n_fail = 0;
  always #5 clk = ~clk;
  alu_issue_ctrl dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_instr(in_instr), .in_rs1(in_rs1), .in_rs2(in_rs2),
    .alu_a(alu_a), .alu_b(alu_b), .alu_sel(alu_sel), .alu_result(alu_result),
    .alu_zero(alu_zero), .alu_carry(alu_carry), .alu_overflow(alu_overflow),
    .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
    .out_zero(out_zero), .out_carry(out_carry), .out_overflow(out_overflow),
    .out_illegal(out_illegal), .out_trap(out_trap)
  );
  // behavioural 32-bit ALU the controller drives
  assign add_s = {1'b0, alu_a} + {1'b0, alu_b};
  assign sub_s = {1'b0, alu_a} + {1'b0, ~alu_b} + 33'd1;
  always_comb begin
    alu_result = '0;
    alu_carry = 1'b0;
    alu_overflow = 1'b0;
    case (alu_sel)
      ALU_AND: alu_result = alu_a & alu_b;
      ALU_OR:  alu_result = alu_a | alu_b;
      ALU_ADD: begin
        alu_result = add_s[31:0];
        alu_carry = add_s[32];
        alu_overflow = (alu_a[31] == alu_b[31]) && (add_s[31] != alu_a[31]);
      end
      ALU_SUB: begin
        alu_result = sub_s[31:0];
        alu_carry = sub_s[32];
        alu_overflow = (alu_a[31] != alu_b[31]) && (sub_s[31] != alu_a[31]);
      end
      ALU_SLT: alu_result = {31'b0, $signed(alu_a) < $signed(alu_b)};
      ALU_NOR: alu_result = ~(alu_a | alu_b);
      ALU_EQ:  alu_result = {31'b0, alu_a == alu_b};
      default: ;
    endcase
  end
  assign alu_zero = alu_result == 32'd0;
  typedef struct {
    logic [31:0] instr, rs1, rs2;
    logic [3:0]  sel;
    logic [31:0] b, res;
    logic        z, c, v, ill, trap;
  } vec_t;
  vec_t vecs[19];
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask
  task automatic drive(input logic [31:0] instr, input logic [31:0] rs1, input logic [31:0] rs2);
    in_valid = 1'b1;
    in_instr = instr;
    in_rs1 = rs1;
    in_rs2 = rs2;
  endtask
  initial begin
    vecs[0]  = '{32'h402081B3, 32'd5, 32'd7, ALU_SUB, 32'd7, 32'hFFFFFFFE, 0, 0, 0, 0, 0};
    vecs[1]  = '{32'h402081B3, 32'd7, 32'd5, ALU_SUB, 32'd5, 32'd2, 0, 1, 0, 0, 0};
    vecs[2]  = '{32'h002081B3, 32'd3, 32'd4, ALU_ADD, 32'd4, 32'd7, 0, 0, 0, 0, 0};
    vecs[3]  = '{32'h002081B3, 32'h7FFFFFFF, 32'd1, ALU_ADD, 32'd1, TRAP ? 32'd0 : 32'h80000000, 0, 0, 1, 0, TRAP};
    vecs[4]  = '{32'h0020F1B3, 32'hFF00FF00, 32'h0FF00FF0, ALU_AND, 32'h0FF00FF0, 32'h0F000F00, 0, 0, 0, 0, 0};
    vecs[5]  = '{32'h0020E1B3, 32'h000000F0, 32'h0000000F, ALU_OR, 32'h0000000F, 32'h000000FF, 0, 0, 0, 0, 0};
    vecs[6]  = '{32'h0020A1B3, 32'hFFFFFFFF, 32'd1, ALU_SLT, 32'd1, 32'd1, 0, 0, 0, 0, 0};
    vecs[7]  = '{32'h0020A1B3, 32'd5, 32'd5, ALU_SLT, 32'd5, 32'd0, 1, 0, 0, 0, 0};
    vecs[8]  = '{32'hFFF08193, 32'd0, 32'h00001234, ALU_ADD, 32'hFFFFFFFF, 32'hFFFFFFFF, 0, 0, 0, 0, 0};
    vecs[9]  = '{32'h0F00F193, 32'hFFFFFFFF, 32'd3, ALU_AND, 32'h000000F0, 32'h000000F0, 0, 0, 0, 0, 0};
    vecs[10] = '{32'h00F0E193, 32'h00000100, 32'd3, ALU_OR, 32'h0000000F, 32'h0000010F, 0, 0, 0, 0, 0};
    vecs[11] = '{32'hFFE0A193, 32'hFFFFFFFF, 32'd3, ALU_SLT, 32'hFFFFFFFE, 32'd0, 1, 0, 0, 0, 0};
    vecs[12] = '{32'h00108193, 32'h7FFFFFFF, 32'd3, ALU_ADD, 32'd1, 32'h80000000, 0, 0, 1, 0, 0};
    vecs[13] = '{32'h00208063, 32'd9, 32'd9, ALU_EQ, 32'd9, 32'd1, 0, 0, 0, 0, 0};
    vecs[14] = '{32'h00208063, 32'd9, 32'd8, ALU_EQ, 32'd8, 32'd0, 1, 0, 0, 0, 0};
    vecs[15] = '{32'h0000A183, 32'd5, 32'd6, ALU_ADD, 32'd0, 32'd0, 0, 0, 0, 1, 0};
    vecs[16] = '{32'h022081B3, 32'd5, 32'd6, ALU_ADD, 32'd0, 32'd0, 0, 0, 0, 1, 0};
    vecs[17] = '{32'h4020F1B3, 32'd5, 32'd6, ALU_ADD, 32'd0, 32'd0, 0, 0, 0, 1, 0};
    vecs[18] = '{32'h00209063, 32'd5, 32'd6, ALU_ADD, 32'd0, 32'd0, 0, 0, 0, 1, 0};
    reset = 1'b1;
    in_valid = 1'b0;
    in_instr = '0;
    in_rs1 = '0;
    in_rs2 = '0;
    out_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst in_ready", {31'b0, in_ready}, 32'd0);
    chk("rst out_valid", {31'b0, out_valid}, 32'd0);
    chk("rst out_result", out_result, 32'd0);
    chk("rst flags", {26'b0, out_zero, out_carry, out_overflow, out_illegal, out_trap, 1'b0}, 32'd0);
    chk("rst alu_a", alu_a, 32'd0);
    chk("rst alu_b", alu_b, 32'd0);
    chk("rst alu_sel", {28'b0, alu_sel}, 32'd0);
    reset = 1'b0;
    #1;
    chk("idle in_ready", {31'b0, in_ready}, 32'd1);
    for (int i = 0; i < 19; i++) begin
      drive(vecs[i].instr, vecs[i].rs1, vecs[i].rs2);
      out_ready = 1'b1;
      chk($sformatf("v%0d in_ready", i), {31'b0, in_ready}, 32'd1);
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0;
      chk($sformatf("v%0d exec out_valid", i), {31'b0, out_valid}, 32'd0);
      chk($sformatf("v%0d alu_sel", i), {28'b0, alu_sel}, {28'b0, vecs[i].sel});
      chk($sformatf("v%0d alu_a", i), alu_a, vecs[i].ill ? 32'd0 : vecs[i].rs1);
      chk($sformatf("v%0d alu_b", i), alu_b, vecs[i].b);
      @(posedge clk);
      @(negedge clk);
      chk($sformatf("v%0d out_valid", i), {31'b0, out_valid}, 32'd1);
      chk($sformatf("v%0d out_result", i), out_result, vecs[i].res);
      chk($sformatf("v%0d flags zcvit", i), {27'b0, out_zero, out_carry, out_overflow, out_illegal, out_trap},
          {27'b0, vecs[i].z, vecs[i].c, vecs[i].v, vecs[i].ill, vecs[i].trap});
      @(posedge clk);
      @(negedge clk);
      chk($sformatf("v%0d retire out_valid", i), {31'b0, out_valid}, 32'd0);
    end
    // back-pressure: result held while out_ready=0, next op accepted on the release cycle
    out_ready = 1'b0;
    drive(32'h002081B3, 32'd3, 32'd4);
    @(posedge clk);
    @(negedge clk);
    drive(32'h0020E1B3, 32'h000000F0, 32'h0000000F);
    @(posedge clk);
    @(negedge clk);
    chk("bp out_valid", {31'b0, out_valid}, 32'd1);
    chk("bp out_result", out_result, 32'd7);
    for (int k = 0; k < 5; k++) begin
      @(posedge clk);
      @(negedge clk);
      chk($sformatf("bp hold%0d valid", k), {31'b0, out_valid}, 32'd1);
      chk($sformatf("bp hold%0d result", k), out_result, 32'd7);
      chk($sformatf("bp hold%0d in_ready", k), {31'b0, in_ready}, 32'd0);
    end
    out_ready = 1'b1;
    #1;
    chk("bp release in_ready", {31'b0, in_ready}, 32'd1);
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    chk("bp next exec out_valid", {31'b0, out_valid}, 32'd0);
    chk("bp next alu_sel", {28'b0, alu_sel}, {28'b0, ALU_OR});
    @(posedge clk);
    @(negedge clk);
    chk("bp next out_valid", {31'b0, out_valid}, 32'd1);
    chk("bp next out_result", out_result, 32'h000000FF);
    @(posedge clk);
    @(negedge clk);
    // reset while in EXEC discards the pending result
    drive(32'h402081B3, 32'd5, 32'd7);
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("rexec out_valid", {31'b0, out_valid}, 32'd0);
    chk("rexec in_ready during reset", {31'b0, in_ready}, 32'd0);
    chk("rexec alu_sel", {28'b0, alu_sel}, 32'd0);
    reset = 1'b0;
    #1;
    chk("rexec in_ready after", {31'b0, in_ready}, 32'd1);
    @(posedge clk);
    @(negedge clk);
    chk("rexec no stale result", {31'b0, out_valid}, 32'd0);
    chk("rexec out_result", out_result, 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
